counter_bank: RTL and testbench

//   Bank of CHANNELS independent WIDTH-bit counters with per-channel direction,

---
 rtl/counter_bank_pkg.sv | 24 ++
 rtl/counter_channel.sv | 74 +++++++
 rtl/counter_bank.sv | 58 +++++
 tb/tb_counter_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// Shared types for the counter bank: counting modes, per-channel FSM states
// and the width of each channel's mode field.
package counter_bank_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_t;

  typedef enum logic {
    ARMED = 1'b0,
    DONE  = 1'b1
  } cnt_state_t;

  // SAT and ONESHOT both park on the terminal value; WRAP and the reserved code wrap.
  function automatic logic mode_holds(input cnt_mode_t mode);
    return (mode == CNT_SAT) || (mode == CNT_ONESHOT);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: value register, one-cycle terminal-count pulse and
// the ARMED/DONE one-shot FSM.
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              dir_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  limit_i,
  input  logic [WIDTH-1:0]  load_value_i,
  output logic [WIDTH-1:0]  value_o,
  output logic              tc_o,
  output logic              done_o
);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             tc_q, tc_d;
  logic             at_term;
  cnt_mode_t        mode;

  assign mode = cnt_mode_t'(mode_i);

  // Counting up, anything at or beyond the limit is treated as terminal.
  assign at_term = dir_i ? (value_q >= limit_i) : (value_q == '0);

  // NOTE: every signal driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    tc_d    = 1'b0;
    if (clr_i) begin
      value_d = '0;
      state_d = ARMED;
    end else if (load_i) begin
      value_d = load_value_i;
      state_d = ARMED;
    end else if (en_i && (state_q == ARMED)) begin
      if (!at_term) begin
        value_d = dir_i ? value_q + WIDTH'(1) : value_q - WIDTH'(1);
        tc_d    = dir_i ? (value_d == limit_i) : (value_d == '0);
        if (tc_d && (mode == CNT_ONESHOT)) state_d = DONE;
      end else if (!mode_holds(mode)) begin
        // Wrap target is a terminal again only when the limit is zero.
        value_d = dir_i ? '0 : limit_i;
        tc_d    = (limit_i == '0);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARMED;
      value_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      tc_q    <= tc_d;
    end
  end

  assign value_o = value_q;
  assign tc_o    = tc_q;
  assign done_o  = (state_q == DONE);

endmodule

// File: rtl/counter_bank.sv
// Bank of independent counter channels with packed per-channel ports.
// Optional snapshot register enabled by defining CNT_SNAPSHOT_EN.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CHANNELS-1:0]        en_i,
  input  logic [CHANNELS-1:0]        clr_i,
  input  logic [CHANNELS-1:0]        load_i,
  input  logic [CHANNELS-1:0]        dir_i,
  input  logic [MODE_W*CHANNELS-1:0] mode_i,
  input  logic [WIDTH*CHANNELS-1:0]  limit_i,
  input  logic [WIDTH*CHANNELS-1:0]  load_value_i,
  output logic [WIDTH*CHANNELS-1:0]  value_o,
  output logic [CHANNELS-1:0]        tc_o,
  output logic [CHANNELS-1:0]        done_o,
  input  logic                       snap_i,
  output logic [WIDTH*CHANNELS-1:0]  snap_value_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    counter_channel #(.WIDTH(WIDTH)) u_channel (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (en_i[c]),
      .clr_i        (clr_i[c]),
      .load_i       (load_i[c]),
      .dir_i        (dir_i[c]),
      .mode_i       (mode_i[MODE_W*c +: MODE_W]),
      .limit_i      (limit_i[WIDTH*c +: WIDTH]),
      .load_value_i (load_value_i[WIDTH*c +: WIDTH]),
      .value_o      (value_o[WIDTH*c +: WIDTH]),
      .tc_o         (tc_o[c]),
      .done_o       (done_o[c])
    );
  end

`ifdef CNT_SNAPSHOT_EN
  logic [WIDTH*CHANNELS-1:0] snap_q;

  // Captures the registered values, i.e. the pre-update count of this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       snap_q <= '0;
    else if (snap_i) snap_q <= value_o;
  end

  assign snap_value_o = snap_q;
`else
  logic unused_snap;
  assign unused_snap  = snap_i;
  assign snap_value_o = '0;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed literal scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_counter_bank;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [CH-1:0]   en_i, clr_i, load_i, dir_i;
  logic [2*CH-1:0] mode_i;
  logic [W*CH-1:0] limit_i, load_value_i, value_o, snap_value_o;
  logic [CH-1:0]   tc_o, done_o;
  logic            snap_i;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  int unsigned m_val  [CH] = '{default: 0};
  bit          m_tc   [CH] = '{default: 0};
  bit          m_done [CH] = '{default: 0};
  int unsigned m_snap [CH] = '{default: 0};

  counter_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .load_i       (load_i),
    .dir_i        (dir_i),
    .mode_i       (mode_i),
    .limit_i      (limit_i),
    .load_value_i (load_value_i),
    .value_o      (value_o),
    .tc_o         (tc_o),
    .done_o       (done_o),
    .snap_i       (snap_i),
    .snap_value_o (snap_value_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one channel, straight from the rules:
  // priority clr > load > en, terminal = limit (up, at or above) or 0 (down).
  task automatic model_step(input int c);
    int unsigned lim, v;
    int          md;
    bit          up, at_term;
    lim = limit_i[W*c +: W];
    v   = m_val[c];
    md  = mode_i[2*c +: 2];
    up  = dir_i[c];
    m_tc[c] = 1'b0;
    if (clr_i[c]) begin
      m_val[c] = 0; m_done[c] = 1'b0;
    end else if (load_i[c]) begin
      m_val[c] = load_value_i[W*c +: W]; m_done[c] = 1'b0;
    end else if (en_i[c] && !m_done[c]) begin
      at_term = up ? (v >= lim) : (v == 0);
      if (!at_term) begin
        v = (v + (up ? 1 : MOD - 1)) % MOD;
        m_tc[c]   = (v == (up ? lim : 0));
        m_done[c] = m_tc[c] && (md == 2);
      end else if (!(md == 1 || md == 2)) begin
        v = up ? 0 : lim;
        m_tc[c] = (lim == 0);
      end
      m_val[c] = v;
    end
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < CH; c++) begin
        m_val[c] = 0; m_tc[c] = 0; m_done[c] = 0; m_snap[c] = 0;
      end
    end else begin
`ifdef CNT_SNAPSHOT_EN
      if (snap_i) for (int c = 0; c < CH; c++) m_snap[c] = m_val[c];
`endif
      for (int c = 0; c < CH; c++) model_step(c);
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("ch%0d value", c), value_o[W*c +: W], m_val[c]);
        check($sformatf("ch%0d tc", c), tc_o[c], m_tc[c]);
        check($sformatf("ch%0d done", c), done_o[c], m_done[c]);
        check($sformatf("ch%0d snap", c), snap_value_o[W*c +: W], m_snap[c]);
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_ch(input int c, input bit en, input bit clr, input bit load, input bit dir,
                        input logic [1:0] mode, input logic [W-1:0] lim, input logic [W-1:0] lv);
    en_i[c]   = en;
    clr_i[c]  = clr;
    load_i[c] = load;
    dir_i[c]  = dir;
    mode_i[2*c +: 2]       = mode;
    limit_i[W*c +: W]      = lim;
    load_value_i[W*c +: W] = lv;
  endtask

  initial begin
    int unsigned exp_v[8];
    bit          exp_t[8];
    bit          exp_d[8];

    rst_i = 1'b1;
    en_i = '0; clr_i = '0; load_i = '0; dir_i = '0;
    mode_i = '0; limit_i = '0; load_value_i = '0; snap_i = 1'b0;
    #12;
    check("reset value", value_o, 0);
    check("reset tc", tc_o, 0);
    check("reset done", done_o, 0);
    check("reset snap", snap_value_o, 0);
    #5 rst_i = 1'b0;
    cmp_en = 1'b1;
    cycle();

    // WRAP up, limit 5
    set_ch(0, 1, 0, 0, 1, 2'b00, 8'd5, 8'd0);
    exp_v[0:6] = '{1, 2, 3, 4, 5, 0, 1};
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("wrap_up value", value_o[7:0], exp_v[i]);
      check("wrap_up tc", tc_o[0], exp_v[i] == 5);
    end

    // WRAP down, limit 9, load 2
    set_ch(0, 0, 0, 1, 0, 2'b00, 8'd9, 8'd2);
    cycle();
    check("wrap_dn load", value_o[7:0], 2);
    check("wrap_dn load tc", tc_o[0], 0);
    en_i[0] = 1'b1; load_i[0] = 1'b0;
    exp_v[0:3] = '{1, 0, 9, 8};
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("wrap_dn value", value_o[7:0], exp_v[i]);
      check("wrap_dn tc", tc_o[0], exp_v[i] == 0);
    end

    // SAT up, limit 200, load 198
    set_ch(0, 0, 0, 1, 1, 2'b01, 8'd200, 8'd198);
    cycle();
    en_i[0] = 1'b1; load_i[0] = 1'b0;
    exp_v[0:2] = '{199, 200, 200};
    exp_t[0:2] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("sat value", value_o[7:0], exp_v[i]);
      check("sat tc", tc_o[0], exp_t[i]);
      check("sat done", done_o[0], 0);
    end

    // ONESHOT up, limit 3
    set_ch(0, 0, 0, 1, 1, 2'b10, 8'd3, 8'd0);
    cycle();
    en_i[0] = 1'b1; load_i[0] = 1'b0;
    exp_v[0:4] = '{1, 2, 3, 3, 3};
    exp_t[0:4] = '{0, 0, 1, 0, 0};
    exp_d[0:4] = '{0, 0, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("oneshot value", value_o[7:0], exp_v[i]);
      check("oneshot tc", tc_o[0], exp_t[i]);
      check("oneshot done", done_o[0], exp_d[i]);
    end
    mode_i[1:0] = 2'b00;
    cycle();
    check("oneshot mode change keeps done", done_o[0], 1);
    mode_i[1:0] = 2'b10; load_i[0] = 1'b1;
    cycle();
    check("oneshot rearm value", value_o[7:0], 0);
    check("oneshot rearm done", done_o[0], 0);
    load_i[0] = 1'b0;
    cycle();
    check("oneshot resume", value_o[7:0], 1);

    // Same-cycle clr + load + en on ch1 while ch0 keeps counting
    set_ch(0, 1, 0, 0, 1, 2'b00, 8'd200, 8'd0);
    set_ch(1, 1, 0, 0, 1, 2'b00, 8'd100, 8'd0);
    repeat (3) cycle();
    check("ch1 pre-clear", value_o[15:8], 3);
    set_ch(1, 1, 1, 1, 1, 2'b00, 8'd100, 8'd77);
    cycle();
    check("ch1 clr priority", value_o[15:8], 0);
    set_ch(1, 0, 0, 0, 1, 2'b00, 8'd100, 8'd0);

    // limit 0, WRAP up: re-wraps to 0 with a pulse every step
    set_ch(2, 1, 0, 0, 1, 2'b00, 8'd0, 8'd0);
    repeat (2) begin
      cycle();
      check("lim0 value", value_o[23:16], 0);
      check("lim0 tc", tc_o[2], 1);
    end
    en_i[2] = 1'b0;

    // Snapshot coinciding with a count step captures the pre-update value
    set_ch(0, 0, 0, 1, 1, 2'b00, 8'd50, 8'd7);
    cycle();
    load_i[0] = 1'b0; en_i[0] = 1'b1; snap_i = 1'b1;
    cycle();
    snap_i = 1'b0;
    check("snap count", value_o[7:0], 8);
`ifdef CNT_SNAPSHOT_EN
    check("snap value", snap_value_o[7:0], 7);
`else
    check("snap tied off", snap_value_o, 0);
`endif

    // Randomized traffic, with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #1 rst_i = 1'b1;
        #1;
        check("async rst value", value_o, 0);
        check("async rst tc", tc_o, 0);
        check("async rst done", done_o, 0);
        check("async rst snap", snap_value_o, 0);
        #3 rst_i = 1'b0;
      end
      for (int c = 0; c < CH; c++) begin
        if (i % 20 == 0) begin
          dir_i[c]          = 1'($urandom_range(0, 1));
          mode_i[2*c +: 2]  = 2'($urandom_range(0, 3));
          limit_i[W*c +: W] = ($urandom_range(0, 1) != 0) ? W'($urandom_range(1, 12))
                                                          : W'($urandom_range(1, MOD - 1));
        end
        en_i[c]   = ($urandom_range(0, 3) != 0);
        clr_i[c]  = ($urandom_range(0, 15) == 0);
        load_i[c] = ($urandom_range(0, 15) == 0);
        load_value_i[W*c +: W] = W'($urandom_range(0, MOD - 1));
      end
      snap_i = ($urandom_range(0, 7) == 0);
      cycle();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
